// File: rtl/mem_stage_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_ctrl_pkg
// Description : Shared constants for the MEM-stage data-memory initiator:
//               default data/address width, lowest legal data address,
//               wait-counter width and the controller state encodings.
// Revision    : 1.0  initial release
// ============================================================================
package mem_stage_ctrl_pkg;

    localparam int DEF_WORD_LEN  = 32;
    localparam int DEF_DATA_BASE = 1024;

    // Width of the wait-state counter (WAIT_CYCLES is limited to 0..15)
    localparam int CNT_W = 4;

    // Controller state encodings
    localparam logic [1:0] MS_IDLE   = 2'd0;
    localparam logic [1:0] MS_ACCESS = 2'd1;
    localparam logic [1:0] MS_DONE   = 2'd2;

endpackage : mem_stage_ctrl_pkg
`default_nettype wire

// File: rtl/mem_stage_ctrl_wait_counter.sv
`default_nettype none
// ============================================================================
// Module      : mem_wait_counter
// Description : Loadable down-counter with a zero flag. Counts the extra
//               memory wait states of one access; saturates at zero.
// Ports       : clk        in   rising-edge clock
//               rst        in   synchronous active-high reset (count -> 0)
//               i_load     in   load i_load_val (has priority over i_dec)
//               i_load_val in   CNT_W-bit start value
//               i_dec      in   decrement request, ignored at zero
//               o_zero     out  count is zero
// Revision    : 1.0  initial release
// ============================================================================
module mem_wait_counter
    import mem_stage_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule : mem_wait_counter
`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_ctrl
// Description : MEM-stage initiator for the data memory. Accepts one load or
//               store per instruction, stalls the pipeline until the access
//               completes, inserts WAIT_CYCLES extra memory cycles, drops
//               illegal accesses (flagging acc_err) and registers load data.
// Ports       : clk, rst              clock, synchronous active-high reset
//               MEM_R_EN, MEM_W_EN    load / store request from EX/MEM
//               ALU_result, ST_value  byte address and store data
//               stall                 freeze pipeline registers and PC
//               rdata                 load result, held until next load done
//               done                  one-cycle completion pulse
//               acc_err               sticky illegal-access flag
//               mem_wr_en, mem_rd_en  dataMem strobes
//               mem_addr, mem_wdata   dataMem address / write data
//               mem_rdata             dataMem read data (combinational)
// Revision    : 1.0  initial release
// ============================================================================
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int WORD_LEN    = DEF_WORD_LEN,
    parameter int DATA_BASE   = DEF_DATA_BASE,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                MEM_R_EN,
    input  logic                MEM_W_EN,
    input  logic [WORD_LEN-1:0] ALU_result,
    input  logic [WORD_LEN-1:0] ST_value,
    output logic                stall,
    output logic [WORD_LEN-1:0] rdata,
    output logic                done,
    output logic                acc_err,
    output logic                mem_wr_en,
    output logic                mem_rd_en,
    output logic [WORD_LEN-1:0] mem_addr,
    output logic [WORD_LEN-1:0] mem_wdata,
    input  logic [WORD_LEN-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0]    C_WAIT = CNT_W'(WAIT_CYCLES);
    localparam logic [WORD_LEN-1:0] C_BASE = WORD_LEN'(DATA_BASE);

    logic [1:0]          r_state;
    logic [WORD_LEN-1:0] r_addr;
    logic [WORD_LEN-1:0] r_wdata;
    logic [WORD_LEN-1:0] r_rdata;
    logic                r_is_store;
    logic                r_acc_err;

    logic w_req;
    logic w_illegal;
    logic w_cnt_zero;
    logic w_cnt_load;
    logic w_in_access;
    logic w_last;

    assign w_req     = MEM_R_EN | MEM_W_EN;
    assign w_illegal = (ALU_result[1:0] != 2'b00) | (ALU_result < C_BASE)
                     | (MEM_R_EN & MEM_W_EN);

    // Counter is armed only for legal accesses; it counts down through ACCESS
    assign w_cnt_load = (r_state == MS_IDLE) & w_req & ~w_illegal;

    mem_wait_counter u_wait_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (C_WAIT),
        .i_dec      (r_state == MS_ACCESS),
        .o_zero     (w_cnt_zero)
    );

    // Memory-facing signals are qualified by ~rst so that a reset landing on
    // the final ACCESS cycle can never issue the write.
    assign w_in_access = (r_state == MS_ACCESS) & ~rst;
    assign w_last      = w_in_access & w_cnt_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= MS_IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_is_store <= 1'b0;
            r_acc_err  <= 1'b0;
        end else begin
            case (r_state)
                MS_IDLE: begin
                    if (w_req) begin
                        r_addr     <= ALU_result;
                        r_wdata    <= ST_value;
                        r_is_store <= MEM_W_EN & ~MEM_R_EN;
                        if (w_illegal) begin
                            r_acc_err <= 1'b1;
                            // Any illegal access with a read component
                            // (including R+W conflicts) returns zero.
                            if (MEM_R_EN) begin
                                r_rdata <= '0;
                            end
                            r_state <= MS_DONE;
                        end else begin
                            r_state <= MS_ACCESS;
                        end
                    end
                end
                MS_ACCESS: begin
                    if (w_cnt_zero) begin
                        if (!r_is_store) begin
                            r_rdata <= mem_rdata;
                        end
                        r_state <= MS_DONE;
                    end
                end
                MS_DONE: begin
                    r_state <= MS_IDLE;
                end
                default: begin
                    r_state <= MS_IDLE;
                end
            endcase
        end
    end

    // Stall is raised combinationally in the request cycle so the pipeline
    // freezes before the EX/MEM register can advance.
    assign stall     = ~rst & (((r_state == MS_IDLE) & w_req) | (r_state == MS_ACCESS));
    assign done      = ~rst & (r_state == MS_DONE);
    assign rdata     = r_rdata;
    assign acc_err   = r_acc_err;
    assign mem_rd_en = w_in_access & ~r_is_store;
    assign mem_wr_en = w_last & r_is_store;
    assign mem_addr  = w_in_access ? r_addr  : '0;
    assign mem_wdata = w_in_access ? r_wdata : '0;

endmodule : mem_stage_ctrl
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_ctrl
// Description : Self-checking bench for mem_stage_ctrl. A cycle table drives
//               a WAIT_CYCLES=0 instance; hand sequences exercise a
//               WAIT_CYCLES=3 instance for wait-state and reset-abort cases.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_stage_ctrl;

    logic clk;

    // WAIT_CYCLES = 0 instance
    logic        a_rst, a_r, a_w;
    logic [31:0] a_addr, a_st, a_mrd;
    logic        a_stall, a_done, a_err, a_wr, a_rd;
    logic [31:0] a_rdata, a_maddr, a_mwdata;

    // WAIT_CYCLES = 3 instance
    logic        b_rst, b_r, b_w;
    logic [31:0] b_addr, b_st, b_mrd;
    logic        b_stall, b_done, b_err, b_wr, b_rd;
    logic [31:0] b_rdata, b_maddr, b_mwdata;

    int n_vec = 0;
    int n_err = 0;

    mem_stage_ctrl #(.WORD_LEN(32), .DATA_BASE(1024), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(a_rst), .MEM_R_EN(a_r), .MEM_W_EN(a_w),
        .ALU_result(a_addr), .ST_value(a_st), .stall(a_stall), .rdata(a_rdata),
        .done(a_done), .acc_err(a_err), .mem_wr_en(a_wr), .mem_rd_en(a_rd),
        .mem_addr(a_maddr), .mem_wdata(a_mwdata), .mem_rdata(a_mrd)
    );

    mem_stage_ctrl #(.WORD_LEN(32), .DATA_BASE(1024), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(b_rst), .MEM_R_EN(b_r), .MEM_W_EN(b_w),
        .ALU_result(b_addr), .ST_value(b_st), .stall(b_stall), .rdata(b_rdata),
        .done(b_done), .acc_err(b_err), .mem_wr_en(b_wr), .mem_rd_en(b_rd),
        .mem_addr(b_maddr), .mem_wdata(b_mwdata), .mem_rdata(b_mrd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, r, w;
        logic [31:0] addr, st, mrd;
        logic        stall, done, err, wr, rd;
        logic [31:0] rdata, maddr, mwdata;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rst, input logic r, input logic w,
        input logic [31:0] addr, input logic [31:0] st, input logic [31:0] mrd,
        input logic stall, input logic done, input logic err,
        input logic wr, input logic rd,
        input logic [31:0] rdata, input logic [31:0] maddr, input logic [31:0] mwdata);
        vec_t v;
        v.rst = rst; v.r = r; v.w = w; v.addr = addr; v.st = st; v.mrd = mrd;
        v.stall = stall; v.done = done; v.err = err; v.wr = wr; v.rd = rd;
        v.rdata = rdata; v.maddr = maddr; v.mwdata = mwdata;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    int stalls, wrs, rds, wr_k, done_k;
    logic done_seen;
    logic [31:0] wa, wd;

    initial begin
        a_rst = 1'b1; a_r = 0; a_w = 0; a_addr = 0; a_st = 0; a_mrd = 0;
        b_rst = 1'b1; b_r = 0; b_w = 0; b_addr = 0; b_st = 0; b_mrd = 0;

        //          rst r w addr  st            mrd           stall done err wr rd rdata         maddr mwdata
        tbl.push_back(mk(1,0,0, 0,    0,            0,            0,0,0,0,0, 0,            0,    0));
        tbl.push_back(mk(0,0,0, 0,    0,            0,            0,0,0,0,0, 0,            0,    0));
        // legal load at DATA_BASE
        tbl.push_back(mk(0,1,0, 1024, 0,            0,            1,0,0,0,0, 0,            0,    0));
        tbl.push_back(mk(0,1,0, 1024, 0,            32'hDEADBEEF, 1,0,0,0,1, 0,            1024, 0));
        tbl.push_back(mk(0,0,0, 0,    0,            32'hDEADBEEF, 0,1,0,0,0, 32'hDEADBEEF, 0,    0));
        tbl.push_back(mk(0,0,0, 0,    0,            0,            0,0,0,0,0, 32'hDEADBEEF, 0,    0));
        // out-of-range load: one stall, rdata forced to zero, sticky error
        tbl.push_back(mk(0,1,0, 512,  0,            0,            1,0,0,0,0, 32'hDEADBEEF, 0,    0));
        tbl.push_back(mk(0,0,0, 0,    0,            0,            0,1,1,0,0, 0,            0,    0));
        tbl.push_back(mk(1,0,0, 0,    0,            0,            0,0,1,0,0, 0,            0,    0));
        tbl.push_back(mk(0,0,0, 0,    0,            0,            0,0,0,0,0, 0,            0,    0));
        // misaligned store: no write strobe
        tbl.push_back(mk(0,0,1, 1026, 5,            0,            1,0,0,0,0, 0,            0,    0));
        tbl.push_back(mk(0,0,0, 0,    0,            0,            0,1,1,0,0, 0,            0,    0));
        tbl.push_back(mk(1,0,0, 0,    0,            0,            0,0,1,0,0, 0,            0,    0));
        tbl.push_back(mk(0,0,0, 0,    0,            0,            0,0,0,0,0, 0,            0,    0));
        // read+write conflict
        tbl.push_back(mk(0,1,1, 1040, 7,            0,            1,0,0,0,0, 0,            0,    0));
        tbl.push_back(mk(0,0,0, 0,    0,            0,            0,1,1,0,0, 0,            0,    0));
        tbl.push_back(mk(1,0,0, 0,    0,            0,            0,0,1,0,0, 0,            0,    0));
        tbl.push_back(mk(0,0,0, 0,    0,            0,            0,0,0,0,0, 0,            0,    0));
        // back-to-back load 1032 / store 1036, address changed mid-ACCESS
        tbl.push_back(mk(0,1,0, 1032, 0,            0,            1,0,0,0,0, 0,            0,    0));
        tbl.push_back(mk(0,1,0, 2000, 0,            32'hCAFEF00D, 1,0,0,0,1, 0,            1032, 0));
        tbl.push_back(mk(0,0,1, 1036, 32'hAABBCCDD, 0,            0,1,0,0,0, 32'hCAFEF00D, 0,    0));
        tbl.push_back(mk(0,0,1, 1036, 32'hAABBCCDD, 0,            1,0,0,0,0, 32'hCAFEF00D, 0,    0));
        tbl.push_back(mk(0,0,1, 68,   32'h11111111, 0,            1,0,0,1,0, 32'hCAFEF00D, 1036, 32'hAABBCCDD));
        tbl.push_back(mk(0,0,0, 0,    0,            0,            0,1,0,0,0, 32'hCAFEF00D, 0,    0));
        tbl.push_back(mk(0,0,0, 0,    0,            0,            0,0,0,0,0, 32'hCAFEF00D, 0,    0));

        repeat (2) @(posedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk); #1;
            a_rst = tbl[i].rst; a_r = tbl[i].r; a_w = tbl[i].w;
            a_addr = tbl[i].addr; a_st = tbl[i].st; a_mrd = tbl[i].mrd;
            @(negedge clk);
            chk($sformatf("v%0d.stall", i),  {31'd0, a_stall}, {31'd0, tbl[i].stall});
            chk($sformatf("v%0d.done", i),   {31'd0, a_done},  {31'd0, tbl[i].done});
            chk($sformatf("v%0d.acc_err", i),{31'd0, a_err},   {31'd0, tbl[i].err});
            chk($sformatf("v%0d.wr_en", i),  {31'd0, a_wr},    {31'd0, tbl[i].wr});
            chk($sformatf("v%0d.rd_en", i),  {31'd0, a_rd},    {31'd0, tbl[i].rd});
            chk($sformatf("v%0d.rdata", i),  a_rdata,          tbl[i].rdata);
            chk($sformatf("v%0d.mem_addr", i),  a_maddr,       tbl[i].maddr);
            chk($sformatf("v%0d.mem_wdata", i), a_mwdata,      tbl[i].mwdata);
        end

        // ---- WAIT=3 store to 1028: 5 stall cycles, write on 4th ACCESS cycle
        @(posedge clk); #1; b_rst = 1'b0;
        @(posedge clk); #1;
        b_w = 1'b1; b_addr = 1028; b_st = 32'h12345678;
        stalls = 0; wrs = 0; rds = 0; wr_k = -1; done_k = -1; done_seen = 1'b0;
        wa = 0; wd = 0;
        for (int k = 0; k < 20 && !done_seen; k++) begin
            @(negedge clk);
            if (b_stall) stalls++;
            if (b_rd) rds++;
            if (b_wr) begin wrs++; wr_k = k; wa = b_maddr; wd = b_mwdata; end
            if (b_done) begin
                done_seen = 1'b1; done_k = k;
                b_w = 1'b0; b_addr = 0; b_st = 0;
            end else begin
                @(posedge clk); #1;
                if (k == 1) b_addr = 32'h0000_0777;
            end
        end
        chk("w3.done_seen",  {31'd0, done_seen}, 32'd1);
        chk("w3.done_cycle", done_k, 5);
        chk("w3.stalls",     stalls, 5);
        chk("w3.wr_pulses",  wrs, 1);
        chk("w3.wr_cycle",   wr_k, 4);
        chk("w3.wr_addr",    wa, 1028);
        chk("w3.wr_data",    wd, 32'h12345678);
        chk("w3.rd_strobes", rds, 0);
        chk("w3.acc_err",    {31'd0, b_err}, 32'd0);

        // ---- WAIT=3 store aborted by reset in the 2nd ACCESS cycle
        @(posedge clk); #1;
        @(posedge clk); #1;
        b_w = 1'b1; b_addr = 1028; b_st = 32'h55;
        wrs = 0;
        @(negedge clk); if (b_wr) wrs++;
        @(posedge clk); #1;
        @(negedge clk); if (b_wr) wrs++;
        chk("rst.in_access", {31'd0, b_stall}, 32'd1);
        @(posedge clk); #1; b_rst = 1'b1;
        @(negedge clk); if (b_wr) wrs++;
        @(posedge clk); #1; b_rst = 1'b0; b_w = 1'b0; b_addr = 0; b_st = 0;
        @(negedge clk);
        chk("rst.outs_zero",
            {26'd0, b_stall, b_done, b_err, b_wr, b_rd, |b_maddr}, 32'd0);
        chk("rst.mwdata_zero", b_mwdata, 0);
        chk("rst.rdata_zero",  b_rdata, 0);
        repeat (6) begin
            @(negedge clk); if (b_wr) wrs++;
        end
        chk("rst.no_write", wrs, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mem_stage_ctrl
`default_nettype wire
